add_seq: RTL

Nibble-serial multi-word adder/subtractor that feeds the team's 4-bit ripple-carry slice (`add_4`) one nibble per cycle and collects its sum and carry-out. Operands of WIDTH bits are accepted over a valid/ready handshake. The carry is chained through a register across WIDTH/4 cycles, and the full result is presented over a second valid/ready handshake. It sits between an operand source (register file / sequencer) and a result consumer, trading latency for a single 4-bit adder.

---
 rtl/add_pkg.sv | 12 +
 rtl/add_4.sv | 22 ++
 rtl/add_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_4.sv
// 4-bit ripple-carry adder slice.
module add_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq.sv
// Nibble-serial WIDTH-bit adder/subtractor: one add_4 pass per cycle, carry
// chained through a register, operands and result over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// ADD   | one nibble per cycle through add_4, LSB nibble first
// DONE  | result held on s_o/c_o/ov_o until out_ready_i
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ov_o
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ADD  = ADD;
  localparam logic [1:0] S_DONE = DONE;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("add_seq: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [3:0]       nib_sum;
  logic             nib_co;

  add_4 u_add_4 (
    .a  (x_sh[NIB_W-1:0]),
    .b  (y_sh[NIB_W-1:0]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  assign in_ready_o  = (state == S_IDLE);
  assign out_valid_o = (state == S_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      x_sh  <= '0;
      y_sh  <= '0;
      s_o   <= '0;
      c_o   <= 1'b0;
      ov_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            // subtract as A + ~B + 1; the +1 enters through the carry register
            x_sh  <= x_i;
            y_sh  <= sub_i ? ~y_i : y_i;
            carry <= sub_i | c_i;
            s_o   <= '0;
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          s_o   <= (s_o >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));
          x_sh  <= x_sh >> NIB_W;
          y_sh  <= y_sh >> NIB_W;
          carry <= nib_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            // top nibble is in the slice now, so its bit 3 is the operand MSB
            c_o   <= nib_co;
            ov_o  <= (x_sh[NIB_W-1] == y_sh[NIB_W-1]) &&
                     (nib_sum[NIB_W-1] != x_sh[NIB_W-1]);
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
